rsbus_r2d_extractor: RTL
========================

RSBUS_R2D_EXTRACTOR -- requirements
Module: rsbus_r2d_extractor

Interface
REQ-001 SHALL have parameter NODE_ID, default 8'h00, the local node address matched against header bits [63:56].
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous reset, active-low.
REQ-004 SHALL have port i_sof, input, 1, ring slot start, asserted on a frame's header word.
REQ-005 SHALL have port i_bus, input, 72, ring word: header bit 71 = slot valid, bit 39 = long frame, bits [63:56] = destination.
REQ-006 SHALL have port o_sof, output, 1, i_sof delayed by one cycle.
REQ-007 SHALL have port o_bus, output, 72, ring word delayed by one cycle, with the slot released when its frame is extracted.
REQ-008 SHALL have port frm_o_stb, output, 1, a buffered word is valid.
REQ-009 SHALL have port frm_o_sof, output, 1, the current word is a frame header.
REQ-010 SHALL have port frm_o_bus, output, 72, the buffered frame word.
REQ-011 SHALL have port frm_o_ack, input, 1, the consumer takes the current word.
REQ-012 SHALL have port miss, output, 1, a one-cycle pulse when a matching frame is left on the ring because the buffer is full.
REQ-013 SHALL have port ff_err, output, 1, sticky error flag.

Function
REQ-014 Frame length SHALL be 2 words (header plus 1) when header bit 39 = 0, and 9 words (header plus 8) when bit 39 = 1.
REQ-015 A frame SHALL match when i_sof = 1, i_bus[71] = 1, i_bus[63:56] = NODE_ID, and at least one buffer slot is free.
REQ-016 The buffer SHALL have 2 frame slots of 9x72 bits each, written in ping-pong order and read in the same order.
REQ-017 Write FSM SHALL have states IDLE and CAPT.
- IDLE to CAPT on a match; the header is written as word 0.
- In CAPT, each cycle SHALL write the next i_bus word and increment a 4-bit word counter.
- On the last word, the FSM SHALL commit the slot and return to IDLE.
REQ-018 An i_sof in CAPT before the last word SHALL abort the capture: the slot is discarded and not committed, and ff_err is set.
- The new header SHALL then be evaluated as a fresh match in the same cycle.
REQ-019 A matching header with no free slot SHALL leave the ring word unchanged, pulse miss for 1 cycle, and keep the FSM in IDLE.
REQ-020 Ring path latency SHALL be exactly 1 cycle: o_sof = i_sof and o_bus = i_bus, registered.
- The exception: a captured header is output with bit 71 = 0 and bit 70 = 0.
- Data words of a captured frame SHALL pass unchanged.
REQ-021 The read side SHALL present committed slots only.
- frm_o_stb = 1 while a committed slot is unread.
- frm_o_sof = 1 on word 0 of the slot.
- frm_o_bus SHALL hold stable until frm_o_ack is asserted.
REQ-022 frm_o_ack with frm_o_stb = 1 SHALL advance the read word.
- After the frame's last word is acked, the slot SHALL be freed and the read pointer toggled.
- frm_o_ack with frm_o_stb = 0 SHALL be ignored.
REQ-023 A commit and a free in the same cycle SHALL both take effect, leaving the occupancy count unchanged.
REQ-024 A slot freed in cycle N SHALL be usable for a match in cycle N+1, not in cycle N.
REQ-025 Back-to-back frames SHALL be supported: a header arriving in the cycle after a commit is a valid match.
REQ-026 ff_err SHALL be set by an abort (REQ-018) and SHALL clear only on reset.

Reset
REQ-027 When rst = 0, all outputs SHALL be 0 (o_sof, o_bus[71:68], frm_o_stb, frm_o_sof, miss, ff_err).
- The FSM SHALL go to IDLE, both slots become free, and the pointers and counters are set to 0.
REQ-028 Buffer RAM contents and o_bus[67:0] SHALL be unspecified after reset.
REQ-029 A reset asserted mid-capture or mid-readout SHALL discard all buffered frames; no partial frame SHALL be presented after reset.

Verification
REQ-030 A short frame to NODE_ID (header 0x80..., bit 39 = 0) followed by 1 data word SHALL give:
- one cycle later, o_bus header with bit 71 = 0;
- frm_o_stb rising 1 cycle after the commit, with 2 words delivered and frm_o_sof on the first only.
REQ-031 A long frame to another node SHALL pass all 9 words to o_bus unchanged with 1-cycle latency; frm_o_stb SHALL stay 0 throughout.
REQ-032 Three matching long frames back-to-back with frm_o_ack held at 0 SHALL give:
- frames 1 and 2 buffered;
- on frame 3, a miss pulse and frame 3's header unchanged on o_bus;
- after ack, frames 1 and 2 delivered in order.
REQ-033 A long-frame capture interrupted by i_sof at word 4 SHALL give:
- ff_err = 1 and held;
- the partial frame never presented;
- the new header captured if it matches.
REQ-034 Continuous matching short frames with frm_o_ack tied to 1 SHALL give no miss pulse and a commit and a free in the same cycle.
- Every frame SHALL be delivered in order.
REQ-035 Reset asserted while frm_o_stb = 1 SHALL give frm_o_stb = 0 immediately; after reset is released, a new matching frame SHALL be delivered normally.

Source files
------------

// File: rtl/rsbus_r2d_extractor.sv
// Ring-to-device frame extractor: copies frames addressed to NODE_ID off the
// ring into a two-slot ping-pong buffer, releases their ring slot, and offers
// buffered frames word by word on a valid/ack read port.
module rsbus_r2d_extractor #(
  parameter logic [7:0] NODE_ID = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sof,
  input  logic [71:0] i_bus,
  output logic        o_sof,
  output logic [71:0] o_bus,
  output logic        frm_o_stb,
  output logic        frm_o_sof,
  output logic [71:0] frm_o_bus,
  input  logic        frm_o_ack,
  output logic        miss,
  output logic        ff_err
);

  typedef enum logic {
    IDLE = 1'b0,
    CAPT = 1'b1
  } wr_state_t;

  wr_state_t   state, state_nxt;

  logic [71:0] mem [2][9];
  logic [3:0]  slot_last [2];

  logic        wr_ptr;
  logic        rd_ptr;
  logic [3:0]  wcnt, wcnt_nxt;
  logic [3:0]  wlast, wlast_nxt;
  logic [3:0]  wr_idx;
  logic [3:0]  rcnt;
  logic [1:0]  occ;

  logic        hdr_hit;
  logic        slot_free;
  logic        match;
  logic        take_hdr;
  logic        wr_en;
  logic        commit;
  logic        abort;
  logic        free;

  // Occupancy is the registered count, so a slot freed this cycle only
  // becomes available to a header arriving next cycle.
  assign hdr_hit   = i_sof & i_bus[71] & (i_bus[63:56] == NODE_ID);
  assign slot_free = (occ != 2'd2);
  assign match     = hdr_hit & slot_free;

  assign frm_o_stb = (occ != 2'd0);
  assign frm_o_sof = frm_o_stb & (rcnt == 4'd0);
  assign frm_o_bus = mem[rd_ptr][rcnt];
  assign free      = frm_o_ack & frm_o_stb & (rcnt == slot_last[rd_ptr]);

  // Write FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Write FSM next state: capture, commit on last word, abort on early sof.
  // An aborting sof is re-evaluated as a fresh header in the same cycle.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    wlast_nxt = wlast;
    wr_en     = 1'b0;
    wr_idx    = wcnt;
    commit    = 1'b0;
    abort     = 1'b0;
    take_hdr  = 1'b0;
    case (state)
      IDLE: begin
        take_hdr = match;
      end
      CAPT: begin
        if (i_sof) begin
          abort    = 1'b1;
          take_hdr = match;
          if (!match) state_nxt = IDLE;
        end else begin
          wr_en = 1'b1;
          if (wcnt == wlast) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end else begin
            wcnt_nxt = wcnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take_hdr) begin
      wr_en     = 1'b1;
      wr_idx    = 4'd0;
      wcnt_nxt  = 4'd1;
      wlast_nxt = i_bus[39] ? 4'd8 : 4'd1;
      state_nxt = CAPT;
    end
  end

  // Write-side counters, slot lengths, error and miss flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt         <= '0;
      wlast        <= '0;
      wr_ptr       <= 1'b0;
      slot_last[0] <= '0;
      slot_last[1] <= '0;
      ff_err       <= 1'b0;
      miss         <= 1'b0;
    end else begin
      wcnt   <= wcnt_nxt;
      wlast  <= wlast_nxt;
      ff_err <= ff_err | abort;
      miss   <= hdr_hit & ~slot_free;
      if (commit) begin
        slot_last[wr_ptr] <= wlast;
        wr_ptr            <= ~wr_ptr;
      end
    end
  end

  // Frame buffer storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr][wr_idx] <= i_bus;
  end

  // Read side: word pointer, slot pointer and committed-slot count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      rcnt   <= '0;
      occ    <= '0;
    end else begin
      if (frm_o_ack && frm_o_stb) begin
        if (free) begin
          rcnt   <= '0;
          rd_ptr <= ~rd_ptr;
        end else begin
          rcnt <= rcnt + 4'd1;
        end
      end
      case ({commit, free})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Ring pass-through with one cycle latency; captured headers lose their slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_sof <= 1'b0;
      o_bus <= '0;
    end else begin
      o_sof <= i_sof;
      o_bus <= take_hdr ? {2'b00, i_bus[69:0]} : i_bus;
    end
  end

endmodule
